mhp_tx: RTL
===========

MHP_TX -- requirements
Module: mhp_tx

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 16'd512, giving the largest payload size accepted, in bytes.
REQ-002 SHALL have i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have i_start, input, 1 bit: request to transmit one MHP frame.
REQ-005 SHALL have i_dst, i_src and i_size, inputs, 16 bits each: destination address, source address and payload byte count, sampled at start.
REQ-006 SHALL have i_dtype, input, 8 bits: MHP type byte, sampled at start.
REQ-007 SHALL have o_busy, output, 1 bit: frame in progress.
REQ-008 SHALL have o_done, output, 1 bit: one-cycle pulse marking frame completion.
REQ-009 SHALL have o_err, output, 1 bit: one-cycle pulse marking a rejected start.
REQ-010 SHALL have i_pdata, input, 8 bits, and i_pvalid, input, 1 bit: payload byte source.
REQ-011 SHALL have o_pready, output, 1 bit: payload byte consumed when i_pvalid and o_pready are both high.
REQ-012 SHALL have o_wdata, output, 8 bits, o_wvalid, output, 1 bit, and i_wready, input, 1 bit: Ethernet write side.

Function
REQ-013 Frame byte order SHALL be dst[15:8], dst[7:0], src[15:8], src[7:0], size[15:8], size[7:0], dtype, payload×size, csum[15:8], csum[7:0].
REQ-014 csum SHALL be the 16-bit sum, mod 2^16, of every preceding frame byte, each byte zero-extended.
REQ-015 The FSM SHALL have states IDLE, HDR, PAYLOAD and CSUM; o_busy SHALL be high exactly when state ≠ IDLE.
REQ-016 In IDLE, i_start=1 with i_size ≤ MAX_SIZE SHALL latch all user fields, clear csum and enter HDR; o_wvalid=1 with o_wdata=dst[15:8] the next cycle.
REQ-017 In IDLE, i_start=1 with i_size > MAX_SIZE SHALL pulse o_err for 1 cycle and stay in IDLE; no byte is emitted.
REQ-018 i_start SHALL be ignored while o_busy=1.
REQ-019 A byte transfers on a cycle with o_wvalid & i_wready; o_wdata and o_wvalid SHALL hold stable while o_wvalid=1 and i_wready=0.
REQ-020 On each transfer the next byte SHALL load on the same edge, giving one byte per cycle under continuous i_wready=1.
REQ-021 HDR SHALL use a 3-bit index 0..6; after the dtype byte it SHALL enter PAYLOAD if size>0, else CSUM.
REQ-022 In PAYLOAD: o_pready = (!o_wvalid | i_wready) & (remaining > 0).
REQ-023 An accepted payload byte SHALL load into o_wdata with o_wvalid=1 and be added to csum.
REQ-024 With i_pvalid=0 and the output drained, o_wvalid SHALL go 0; the stall SHALL be unbounded.
REQ-025 A 16-bit remaining counter SHALL decrement per accepted payload byte; the state SHALL go to CSUM when the last payload byte loads.
REQ-026 CSUM SHALL emit csum[15:8] then csum[7:0]; csum includes all bytes up to the last payload byte.
REQ-027 On transfer of csum[7:0], the block SHALL enter IDLE, set o_wvalid=0 and pulse o_done for 1 cycle, with o_done aligned to the first IDLE cycle.
REQ-028 o_pready SHALL be 0 outside PAYLOAD.

Reset
REQ-029 i_rst=1 SHALL immediately force state=IDLE and o_busy, o_done, o_err, o_pready, o_wvalid = 0, o_wdata=8'h00, csum and counters cleared.
REQ-030 Reset mid-frame SHALL abandon the partial frame; the first start after reset is a fresh frame.

Verification
REQ-031 dst=FFFF src=0000 size=0 dtype=83, wready=1 -> FF FF 00 00 00 00 83 02 81 on 9 consecutive cycles, then o_done pulse.
REQ-032 dst=1234 src=5678 size=3 dtype=10, payload 01 02 03 always valid -> 12 34 56 78 00 03 10 01 02 03 01 2D.
REQ-033 Same frame as REQ-032 with i_wready toggling every cycle and i_pvalid low 5 cycles mid-payload -> identical byte sequence, held data stable, no duplicate or dropped bytes.
REQ-034 size=0200, dst=src=0000, dtype=00, 512 payload bytes FF -> checksum wraps, csum bytes FE 02.
REQ-035 size=MAX_SIZE+1 -> o_err 1-cycle pulse, o_wvalid stays 0, o_busy stays 0; i_start during busy -> ignored.
REQ-036 Assert i_rst during PAYLOAD -> all outputs 0 the same cycle; a new start then produces a complete correct frame.

Source files
------------

// File: rtl/mhp_tx_if.sv
// mhp_tx_if -- signal bundle for the MHP frame transmitter.
//   Frame request : i_start, i_dst, i_src, i_size, i_dtype
//   Frame status  : o_busy, o_done, o_err
//   Payload source: i_pdata, i_pvalid, o_pready
//   Ethernet write: o_wdata, o_wvalid, i_wready
// master: the side that requests frames, feeds payload and sinks bytes.
// slave : the transmitter (mhp_tx).
`timescale 1ns/1ps
interface mhp_tx_if;
  logic        i_start;
  logic [15:0] i_dst;
  logic [15:0] i_src;
  logic [15:0] i_size;
  logic [7:0]  i_dtype;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [7:0]  i_pdata;
  logic        i_pvalid;
  logic        o_pready;
  logic [7:0]  o_wdata;
  logic        o_wvalid;
  logic        i_wready;

  modport master (
    output i_start, i_dst, i_src, i_size, i_dtype, i_pdata, i_pvalid, i_wready,
    input  o_busy, o_done, o_err, o_pready, o_wdata, o_wvalid
  );

  modport slave (
    input  i_start, i_dst, i_src, i_size, i_dtype, i_pdata, i_pvalid, i_wready,
    output o_busy, o_done, o_err, o_pready, o_wdata, o_wvalid
  );
endinterface

// File: rtl/mhp_tx.sv
// mhp_tx -- serialises one MHP frame per start request onto a byte stream:
//   dst(2) src(2) size(2) dtype(1) payload(size) csum(2), MSB first.
//   csum is the mod-2^16 sum of all preceding frame bytes.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : mhp_tx_if.slave (request fields, status pulses, payload
//            source handshake, Ethernet write handshake)
// The output byte register always holds the byte currently offered; the
// state says what gets loaded next, so a new byte loads on the same edge
// the previous one transfers (one byte per cycle with i_wready held high).
`timescale 1ns/1ps
module mhp_tx #(
  parameter logic [15:0] MAX_SIZE = 16'd512
) (
  input logic     i_clk,
  input logic     i_rst,
  mhp_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] dst_r, dst_s;
  logic [15:0] src_r, src_s;
  logic [15:0] size_r, size_s;
  logic [7:0]  dtype_r, dtype_s;
  logic [15:0] csum_r, csum_s;
  logic [15:0] rem_r, rem_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  wdata_r, wdata_s;
  logic        wvalid_r, wvalid_s;
  logic        done_r, done_s;
  logic        err_r, err_s;

  logic        xfer_s;
  logic        load_ok_s;
  logic        pready_s;
  logic        accept_s;
  logic [7:0]  hdr_next_s;

  // Running checksum: add one zero-extended byte, wrapping at 16 bits.
  function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] b);
    return sum + {8'h00, b};
  endfunction

  // Header byte at position idx (0..6) of the frame.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] dst,
                                          input logic [15:0] src, input logic [15:0] size,
                                          input logic [7:0] dtype);
    logic [7:0] b;
    case (idx)
      3'd0:    b = dst[15:8];
      3'd1:    b = dst[7:0];
      3'd2:    b = src[15:8];
      3'd3:    b = src[7:0];
      3'd4:    b = size[15:8];
      3'd5:    b = size[7:0];
      3'd6:    b = dtype;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign xfer_s     = wvalid_r & bus.i_wready;
  // The output register can take a new byte when empty or when it drains now.
  assign load_ok_s  = ~wvalid_r | bus.i_wready;
  assign pready_s   = (state_r == PAYLOAD) & load_ok_s & (rem_r != 16'd0);
  assign accept_s   = pready_s & bus.i_pvalid;
  // idx_r never exceeds 5 while a header byte is still to load.
  assign hdr_next_s = hdr_byte(idx_r + 3'd1, dst_r, src_r, size_r, dtype_r);

  // Next-state and datapath decode.
  always_comb begin
    state_s  = state_r;
    dst_s    = dst_r;
    src_s    = src_r;
    size_s   = size_r;
    dtype_s  = dtype_r;
    csum_s   = csum_r;
    rem_s    = rem_r;
    idx_s    = idx_r;
    wdata_s  = wdata_r;
    wvalid_s = wvalid_r;
    done_s   = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_size > MAX_SIZE) begin
            err_s = 1'b1;
          end else begin
            dst_s    = bus.i_dst;
            src_s    = bus.i_src;
            size_s   = bus.i_size;
            dtype_s  = bus.i_dtype;
            rem_s    = bus.i_size;
            idx_s    = 3'd0;
            wdata_s  = bus.i_dst[15:8];
            wvalid_s = 1'b1;
            // Fresh checksum seeded with the first byte being loaded.
            csum_s   = csum_add(16'd0, bus.i_dst[15:8]);
            state_s  = HDR;
          end
        end else begin
          wvalid_s = 1'b0;
        end
      end
      HDR: begin
        if (xfer_s) begin
          idx_s   = idx_r + 3'd1;
          wdata_s = hdr_next_s;
          csum_s  = csum_add(csum_r, hdr_next_s);
          // Loading dtype: pick what follows it in the output register.
          if (idx_r == 3'd5) begin
            if (size_r != 16'd0) begin
              state_s = PAYLOAD;
            end else begin
              state_s = CSUM;
              idx_s   = 3'd0;
            end
          end else begin
            state_s = HDR;
          end
        end else begin
          state_s = HDR;
        end
      end
      PAYLOAD: begin
        if (accept_s) begin
          wdata_s  = bus.i_pdata;
          wvalid_s = 1'b1;
          csum_s   = csum_add(csum_r, bus.i_pdata);
          rem_s    = rem_r - 16'd1;
          if (rem_r == 16'd1) begin
            state_s = CSUM;
            idx_s   = 3'd0;
          end else begin
            state_s = PAYLOAD;
          end
        end else if (xfer_s) begin
          wvalid_s = 1'b0;
        end else begin
          wvalid_s = wvalid_r;
        end
      end
      CSUM: begin
        // idx_r: 0 = last data byte offered, 1 = csum hi offered, 2 = csum lo offered.
        if (xfer_s) begin
          case (idx_r)
            3'd0: begin
              wdata_s = csum_r[15:8];
              idx_s   = 3'd1;
            end
            3'd1: begin
              wdata_s = csum_r[7:0];
              idx_s   = 3'd2;
            end
            default: begin
              wvalid_s = 1'b0;
              done_s   = 1'b1;
              idx_s    = 3'd0;
              state_s  = IDLE;
            end
          endcase
        end else begin
          state_s = CSUM;
        end
      end
      default: begin
        state_s  = IDLE;
        wvalid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= IDLE;
      dst_r    <= 16'd0;
      src_r    <= 16'd0;
      size_r   <= 16'd0;
      dtype_r  <= 8'd0;
      csum_r   <= 16'd0;
      rem_r    <= 16'd0;
      idx_r    <= 3'd0;
      wdata_r  <= 8'h00;
      wvalid_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      dst_r    <= dst_s;
      src_r    <= src_s;
      size_r   <= size_s;
      dtype_r  <= dtype_s;
      csum_r   <= csum_s;
      rem_r    <= rem_s;
      idx_r    <= idx_s;
      wdata_r  <= wdata_s;
      wvalid_r <= wvalid_s;
      done_r   <= done_s;
      err_r    <= err_s;
    end
  end

  assign bus.o_busy   = (state_r != IDLE);
  assign bus.o_done   = done_r;
  assign bus.o_err    = err_r;
  assign bus.o_pready = pready_s;
  assign bus.o_wdata  = wdata_r;
  assign bus.o_wvalid = wvalid_r;

endmodule
